inst_queue: RTL and testbench

//   Parametrised instruction queue between the fetch/icache stage and decode.

---
 rtl/inst_queue_if.sv | 36 +++
 rtl/inst_queue.sv | 91 +++++++++
 tb/tb_inst_queue.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/inst_queue_if.sv
// Fetch->queue->decode bundle: push group, pop count, head window.
// master = fetch/decode side, slave = queue.
interface inst_queue_if #(
  parameter int IN_W   = 2,
  parameter int OUT_W  = 2,
  parameter int DEPTH  = 16,
  parameter int DATA_W = 106
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int NW = $clog2(OUT_W + 1);

  logic                    flush;
  logic                    push_en;
  logic [IN_W-1:0]         push_lvalid;
  logic [IN_W*DATA_W-1:0]  push_data;
  logic                    push_ready;
  logic                    stall;
  logic [NW-1:0]           pop_cnt;
  logic [OUT_W*DATA_W-1:0] out_data;
  logic [OUT_W-1:0]        out_valid;
  logic [CW-1:0]           count;

  modport master (
    output flush, push_en, push_lvalid,
    output push_data, pop_cnt,
    input  push_ready, stall, out_data,
    input  out_valid, count
  );

  modport slave (
    input  flush, push_en, push_lvalid,
    input  push_data, pop_cnt,
    output push_ready, stall, out_data,
    output out_valid, count
  );
endinterface

// File: rtl/inst_queue.sv
// Shared circular instruction queue: compacting IN_W-wide push,
// OUT_W-wide in-order head window, variable pop, flush.
// Ports: clk, rst_n (async low), q (inst_queue_if.slave).
module inst_queue #(
  parameter int IN_W   = 2,
  parameter int OUT_W  = 2,
  parameter int DEPTH  = 16,
  parameter int DATA_W = 106
) (
  input  logic clk,
  input  logic rst_n,
  inst_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     cnt;

  logic              ready;
  logic              acc;
  logic [IN_W-1:0]   wr;
  logic [PW-1:0]     slot [IN_W];
  logic [CW-1:0]     n_push;
  logic [CW-1:0]     n_pop;
  logic [CW-1:0]     free;

  // Registered count only: pop space freed this cycle is not credited.
  assign free  = CW'(DEPTH) - cnt;
  assign ready = free >= CW'(IN_W);
  assign acc   = q.push_en & ready & ~q.flush;

  assign q.push_ready = ready;
  assign q.stall      = ~ready;
  assign q.count      = cnt;

  // Each valid lane lands at tail + (valid lanes below it).
  always_comb begin
    logic [CW-1:0] off;
    off = '0;
    for (int i = 0; i < IN_W; i++) begin
      wr[i]   = acc & q.push_lvalid[i];
      slot[i] = tail + off[PW-1:0];
      off     = off + CW'(wr[i]);
    end
    n_push = off;
  end

  always_comb begin
    logic [CW-1:0] p;
    p = CW'(q.pop_cnt);
    if (p > CW'(OUT_W)) p = CW'(OUT_W);
    if (p > cnt) p = cnt;
    n_pop = q.flush ? '0 : p;
  end

  always_comb begin
    q.out_data  = '0;
    q.out_valid = '0;
    for (int i = 0; i < OUT_W; i++) begin
      q.out_data[i*DATA_W +: DATA_W] = mem[head + PW'(i)];
      q.out_valid[i] = (cnt > CW'(i)) & ~q.flush;
    end
  end

  // Storage is not reset; occupancy tracking alone defines validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < IN_W; i++) begin
      if (wr[i])
        mem[slot[i]] <= q.push_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (q.flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head + n_pop[PW-1:0];
      tail <= tail + n_push[PW-1:0];
      cnt  <= cnt + n_push - n_pop;
    end
  end
endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: vector table plus
// fill, wrap, flush and async-reset sequences.
module tb_inst_queue;
  localparam int IN_W = 2, OUT_W = 2, DEPTH = 16, DW = 106;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_queue_if #(.IN_W(IN_W), .OUT_W(OUT_W),
    .DEPTH(DEPTH), .DATA_W(DW)) q ();

  inst_queue #(.IN_W(IN_W), .OUT_W(OUT_W),
    .DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .q(q)
  );

  int n_tot = 0;
  int n_pass = 0;

  typedef struct {
    logic        en;
    logic [1:0]  lv;
    logic [31:0] pc0, pc1;
    logic [1:0]  pop;
    logic        fl;
    logic [4:0]  e_cnt;
    logic [1:0]  e_val;
    logic [31:0] e_pc0, e_pc1;
    logic        e_rdy;
  } vec_t;

  vec_t vt [9];
  logic [31:0] mq [$];
  logic [31:0] nxt;

  // cause[6:0] exc[7] inst[39:8] pc[71:40] paddr[103:72] pt[104] v[105]
  function automatic logic [DW-1:0] mkd(input logic [31:0] pc);
    return {1'b1, 1'b0, 32'h0, pc, ~pc, 1'b0, 7'h0};
  endfunction

  function automatic logic [31:0] pcof(input int i);
    return q.out_data[i*DW+40 +: 32];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %h want %h", nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic drive(input logic en, input logic [1:0] lv,
                       input logic [31:0] p0, input logic [31:0] p1,
                       input logic [1:0] pop, input logic fl);
    q.push_en     = en;
    q.push_lvalid = lv;
    q.push_data   = {mkd(p1), mkd(p0)};
    q.pop_cnt     = pop;
    q.flush       = fl;
  endtask

  // Model-checked cycle; lane pcs are nxt, nxt+4.
  task automatic op(input logic en, input logic [1:0] lv,
                    input logic [1:0] pop, input logic fl);
    logic rdy, acc;
    int np;
    logic [1:0] ev;
    drive(en, lv, nxt, nxt + 4, pop, fl);
    rdy = (DEPTH - mq.size()) >= 2;
    acc = en & rdy & ~fl;
    ev  = fl ? 2'b00 :
          {mq.size() > 1, mq.size() > 0};
    #1;
    chk("op_pre_ready", 32'(q.push_ready), 32'(rdy));
    chk("op_pre_valid", 32'(q.out_valid), 32'(ev));
    if (fl) begin
      mq.delete();
    end else begin
      np = int'(pop);
      if (np > mq.size()) np = mq.size();
      repeat (np) void'(mq.pop_front());
      if (acc) begin
        if (lv[0]) mq.push_back(nxt);
        if (lv[1]) mq.push_back(nxt + 4);
        nxt = nxt + 8;
      end
    end
    @(posedge clk);
    #1;
    chk("op_count", 32'(q.count), 32'(mq.size()));
    if (mq.size() > 0) chk("op_pc0", pcof(0), mq[0]);
    if (mq.size() > 1) chk("op_pc1", pcof(1), mq[1]);
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] prev;
    vt[0] = '{1, 2'b11, 32'h1c000000, 32'h1c000004, 0, 0,
              2, 2'b11, 32'h1c000000, 32'h1c000004, 1};
    vt[1] = '{1, 2'b10, 32'h00000100, 32'h00000008, 0, 0,
              3, 2'b11, 32'h1c000000, 32'h1c000004, 1};
    vt[2] = '{0, 2'b00, 32'h0, 32'h0, 2, 0,
              1, 2'b01, 32'h00000008, 32'h0, 1};
    vt[3] = '{0, 2'b00, 32'h0, 32'h0, 2, 0,
              0, 2'b00, 32'h0, 32'h0, 1};
    vt[4] = '{1, 2'b01, 32'h00000020, 32'h0, 1, 0,
              1, 2'b01, 32'h00000020, 32'h0, 1};
    vt[5] = '{1, 2'b11, 32'h00000024, 32'h00000028, 1, 0,
              2, 2'b11, 32'h00000024, 32'h00000028, 1};
    vt[6] = '{1, 2'b00, 32'h0, 32'h0, 0, 0,
              2, 2'b11, 32'h00000024, 32'h00000028, 1};
    vt[7] = '{0, 2'b11, 32'h44, 32'h48, 0, 0,
              2, 2'b11, 32'h00000024, 32'h00000028, 1};
    vt[8] = '{1, 2'b11, 32'h50, 32'h54, 2, 1,
              0, 2'b00, 32'h0, 32'h0, 1};

    drive(0, 2'b00, 0, 0, 0, 0);
    #12;
    chk("rst_count", 32'(q.count), 0);
    chk("rst_valid", 32'(q.out_valid), 0);
    chk("rst_ready", 32'(q.push_ready), 1);
    chk("rst_stall", 32'(q.stall), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    prev = 2'b00;
    for (int i = 0; i < 9; i++) begin
      drive(vt[i].en, vt[i].lv, vt[i].pc0, vt[i].pc1,
            vt[i].pop, vt[i].fl);
      #1;
      chk($sformatf("v%0d_pre_valid", i), 32'(q.out_valid),
          32'(vt[i].fl ? 2'b00 : prev));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_count", i), 32'(q.count),
          32'(vt[i].e_cnt));
      chk($sformatf("v%0d_valid", i), 32'(q.out_valid),
          32'(vt[i].e_val));
      chk($sformatf("v%0d_ready", i), 32'(q.push_ready),
          32'(vt[i].e_rdy));
      if (vt[i].e_val[0])
        chk($sformatf("v%0d_pc0", i), pcof(0), vt[i].e_pc0);
      if (vt[i].e_val[1])
        chk($sformatf("v%0d_pc1", i), pcof(1), vt[i].e_pc1);
      prev = vt[i].e_val;
      @(negedge clk);
    end

    // Fill to 15, then a full group must be refused.
    nxt = 32'h1000;
    op(1, 2'b01, 0, 0);
    repeat (7) op(1, 2'b11, 0, 0);
    chk("fill_count15", 32'(q.count), 15);
    chk("fill_stall", 32'(q.stall), 1);
    op(1, 2'b11, 0, 0);
    chk("drop_count", 32'(q.count), 15);
    op(1, 2'b11, 2, 0);

    // Steady push 2 / pop 2 across many wraps.
    repeat (40) op(1, 2'b11, 2, 0);
    chk("wrap_count", 32'(q.count), 13);

    repeat (2) op(0, 2'b00, 2, 0);
    chk("pre_flush_count", 32'(q.count), 9);
    op(1, 2'b11, 2, 1);
    chk("flush_ready", 32'(q.push_ready), 1);
    chk("flush_valid", 32'(q.out_valid), 0);

    // Async reset mid-burst.
    repeat (3) op(1, 2'b11, 0, 0);
    drive(1, 2'b11, nxt, nxt + 4, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(q.count), 0);
    chk("arst_valid", 32'(q.out_valid), 0);
    chk("arst_ready", 32'(q.push_ready), 1);
    chk("arst_stall", 32'(q.stall), 0);
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    op(0, 2'b00, 0, 0);
    op(1, 2'b10, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
